tron_game_ctrl: RTL and testbench

Round sequencer for the two-player light-cycle game. It sits between the frame-timing logic and the object/trace datapath. It decides when player positions and traces may advance, when they are restored to their start values, and when a round ends on a crash. It also keeps the match score and declares the winner.

---
 rtl/tron_pkg.sv | 40 ++++
 rtl/frame_timer.sv | 43 ++++
 rtl/tron_game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_tron_game_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// ============================================================
// tron_pkg : shared types and defaults for the light-cycle round sequencer
// Rev 1.0
// ============================================================
`default_nettype none

package tron_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    COUNTDOWN = 3'd2,
    PLAY      = 3'd3,
    CRASH     = 3'd4,
    GAMEOVER  = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_t;

  localparam int C_FPS          = 60;
  localparam int C_COUNT_SECS   = 3;
  localparam int C_CRASH_FRAMES = 120;
  localparam int C_SPEED_DIV    = 2;
  localparam int C_WIN_SCORE    = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================
// frame_timer : loadable down-counter stepped by frame ticks, with zero flag
// Rev 1.0
// ============================================================
`default_nettype none

module frame_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load wins over a same-cycle tick; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tron_game_ctrl.sv
// ============================================================
// tron_game_ctrl : round/match sequencer for the two-player light-cycle game
// Rev 1.0
// ============================================================
`default_nettype none

module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int FPS          = C_FPS,
  parameter int COUNT_SECS   = C_COUNT_SECS,
  parameter int CRASH_FRAMES = C_CRASH_FRAMES,
  parameter int SPEED_DIV    = C_SPEED_DIV,
  parameter int WIN_SCORE    = C_WIN_SCORE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_crash,
  input  logic       p2_crash,
  output logic       restore_default,
  output logic       move_en,
  output logic [2:0] state,
  output logic [2:0] countdown,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  localparam int TMAX = max2(FPS, CRASH_FRAMES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] C_FPS_M1   = TW'(FPS - 1);
  localparam logic [TW-1:0] C_CRASH_M1 = TW'(CRASH_FRAMES - 1);
  localparam logic [2:0]    C_SECS     = 3'(COUNT_SECS);
  localparam logic [3:0]    C_STEP_MAX = 4'(SPEED_DIV - 1);
  localparam logic [3:0]    C_WIN      = 4'(WIN_SCORE);

  game_state_t state_q, state_d;
  winner_t     winner_q, winner_d;
  logic        start_prev_q;
  logic        c1_q, c1_d, c2_q, c2_d;
  logic        move_q, move_d;
  logic [3:0]  step_q, step_d;
  logic [2:0]  countdown_q, countdown_d;
  logic [3:0]  p1_q, p1_d, p2_q, p2_d;

  logic          w_start_edge;
  logic          w_c1, w_c2;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_zero;

  assign w_start_edge = start & ~start_prev_q;
  assign w_c1         = c1_q | p1_crash;
  assign w_c2         = c2_q | p2_crash;

  frame_timer #(
    .WIDTH(TW)
  ) u_frame_timer (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .load       (w_tmr_load),
    .load_val   (w_tmr_val),
    .zero       (w_tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    c1_d        = 1'b0;
    c2_d        = 1'b0;
    move_d      = 1'b0;
    step_d      = step_q;
    countdown_d = countdown_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;

    case (state_q)
      IDLE: begin
        p1_d        = '0;
        p2_d        = '0;
        winner_d    = WIN_NONE;
        countdown_d = '0;
        if (w_start_edge) begin
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        if (frame_tick) begin
          state_d     = COUNTDOWN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_FPS_M1;
          countdown_d = C_SECS;
        end
      end

      COUNTDOWN: begin
        if (frame_tick && w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = C_FPS_M1;
          if (countdown_q == 3'd1) begin
            state_d     = PLAY;
            countdown_d = '0;
            step_d      = '0;
          end else begin
            countdown_d = countdown_q - 3'd1;
          end
        end
      end

      PLAY: begin
        if (!frame_tick) begin
          c1_d = w_c1;
          c2_d = w_c2;
        end else begin
          step_d = (step_q == C_STEP_MAX) ? 4'd0 : step_q + 4'd1;
          // A crash on the tick claims the frame: score it and withhold the step.
          if (w_c1 || w_c2) begin
            state_d    = CRASH;
            w_tmr_load = 1'b1;
            w_tmr_val  = C_CRASH_M1;
            if (w_c1 && !w_c2) begin
              p2_d = sat_inc(p2_q, C_WIN);
            end else if (w_c2 && !w_c1) begin
              p1_d = sat_inc(p1_q, C_WIN);
            end
          end else if (step_q == C_STEP_MAX) begin
            move_d = 1'b1;
          end
        end
      end

      CRASH: begin
        if (frame_tick && w_tmr_zero) begin
          if (p1_q == C_WIN) begin
            state_d  = GAMEOVER;
            winner_d = WIN_P1;
          end else if (p2_q == C_WIN) begin
            state_d  = GAMEOVER;
            winner_d = WIN_P2;
          end else begin
            state_d = CLEAR;
          end
        end
      end

      GAMEOVER: begin
        if (w_start_edge) begin
          state_d  = CLEAR;
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WIN_NONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The edge detector also samples during reset so a held button is not an edge.
  always_ff @(posedge clock) begin
    start_prev_q <= start;
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= WIN_NONE;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      move_q      <= 1'b0;
      step_q      <= '0;
      countdown_q <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      move_q      <= move_d;
      step_q      <= step_d;
      countdown_q <= countdown_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

  assign restore_default = (state_q == IDLE) || (state_q == CLEAR);
  assign move_en         = move_q;
  assign state           = state_q;
  assign countdown       = countdown_q;
  assign p1_score        = p1_q;
  assign p2_score        = p2_q;
  assign winner          = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_tron_game_ctrl.sv
// ============================================================
// tb_tron_game_ctrl : vector table plus model-checked random run for tron_game_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_tron_game_ctrl;
  import tron_pkg::*;

  localparam int FPS    = 60;
  localparam int SECS   = 3;
  localparam int CRASHF = 120;
  localparam int SDIV   = 2;
  localparam int WIN    = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters, checked against the reference model
  logic       a_rst, a_st, a_tk, a_c1, a_c2;
  logic       a_rd, a_mv;
  logic [2:0] a_state, a_cd;
  logic [3:0] a_s1, a_s2;
  logic [1:0] a_win;

  tron_game_ctrl #(
    .FPS(FPS), .COUNT_SECS(SECS), .CRASH_FRAMES(CRASHF), .SPEED_DIV(SDIV), .WIN_SCORE(WIN)
  ) dut_a (
    .clock(clock), .reset(a_rst), .frame_tick(a_tk), .start(a_st),
    .p1_crash(a_c1), .p2_crash(a_c2), .restore_default(a_rd), .move_en(a_mv),
    .state(a_state), .countdown(a_cd), .p1_score(a_s1), .p2_score(a_s2), .winner(a_win)
  );

  // Instance B: tiny parameters with SPEED_DIV=1, checked by the vector table
  logic       b_rst, b_st, b_tk, b_c1, b_c2;
  logic       b_rd, b_mv;
  logic [2:0] b_state, b_cd;
  logic [3:0] b_s1, b_s2;
  logic [1:0] b_win;

  tron_game_ctrl #(
    .FPS(2), .COUNT_SECS(1), .CRASH_FRAMES(2), .SPEED_DIV(1), .WIN_SCORE(1)
  ) dut_b (
    .clock(clock), .reset(b_rst), .frame_tick(b_tk), .start(b_st),
    .p1_crash(b_c1), .p2_crash(b_c2), .restore_default(b_rd), .move_en(b_mv),
    .state(b_state), .countdown(b_cd), .p1_score(b_s1), .p2_score(b_s2), .winner(b_win)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, st, tk, c1, c2;
    logic [2:0] state;
    logic       rd, mv;
    logic [2:0] cd;
    logic [3:0] s1, s2;
    logic [1:0] win;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int rst, st, tk, c1, c2, input int state, rd, mv, cd, s1, s2, win);
    vec_t v;
    v.rst = 1'(rst); v.st = 1'(st); v.tk = 1'(tk); v.c1 = 1'(c1); v.c2 = 1'(c2);
    v.state = 3'(state); v.rd = 1'(rd); v.mv = 1'(mv); v.cd = 3'(cd);
    v.s1 = 4'(s1); v.s2 = 4'(s2); v.win = 2'(win);
    tbl.push_back(v);
  endtask

  // Reference model: tracks ticks elapsed in each phase rather than down-counters.
  game_state_t m_phase = IDLE;
  int m_n = 0, m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_mv = 0, m_c1 = 0, m_c2 = 0, m_prev = 0;

  task automatic model(input bit rst, st, tk, c1, c2);
    bit sedge;
    if (rst) begin
      m_phase = IDLE; m_n = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_mv = 0; m_c1 = 0; m_c2 = 0; m_prev = st;
      return;
    end
    sedge  = st && !m_prev;
    m_prev = st;
    m_mv   = 0;
    case (m_phase)
      IDLE:      if (sedge) m_phase = CLEAR;
      CLEAR:     if (tk) begin m_phase = COUNTDOWN; m_n = 0; end
      COUNTDOWN: if (tk) begin
        m_n++;
        if (m_n == SECS * FPS) begin m_phase = PLAY; m_n = 0; end
      end
      PLAY: begin
        m_c1 = m_c1 | c1;
        m_c2 = m_c2 | c2;
        if (tk) begin
          m_n++;
          if (m_c1 || m_c2) begin
            if (!m_c2) m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
            else if (!m_c1) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
            m_phase = CRASH;
            m_n = 0;
          end else if (m_n % SDIV == 0) begin
            m_mv = 1;
          end
          m_c1 = 0;
          m_c2 = 0;
        end
      end
      CRASH: if (tk) begin
        m_n++;
        if (m_n == CRASHF) begin
          if (m_s1 == WIN) begin m_phase = GAMEOVER; m_win = 1; end
          else if (m_s2 == WIN) begin m_phase = GAMEOVER; m_win = 2; end
          else m_phase = CLEAR;
        end
      end
      GAMEOVER: if (sedge) begin m_phase = CLEAR; m_s1 = 0; m_s2 = 0; m_win = 0; end
      default: ;
    endcase
  endtask

  int a_cyc   = 0;
  bit last_tk = 0;

  task automatic step_a(input bit rst, st, tk, c1, c2);
    int exp_cd;
    a_rst = rst; a_st = st; a_tk = tk; a_c1 = c1; a_c2 = c2;
    @(posedge clock);
    model(rst, st, tk, c1, c2);
    #1;
    exp_cd = (m_phase == COUNTDOWN) ? SECS - m_n / FPS : 0;
    chk("state",     32'(a_state), 32'(m_phase));
    chk("restore",   32'(a_rd),    32'((m_phase == IDLE) || (m_phase == CLEAR)));
    chk("move_en",   32'(a_mv),    32'(m_mv));
    chk("countdown", 32'(a_cd),    32'(exp_cd));
    chk("p1_score",  32'(a_s1),    32'(m_s1));
    chk("p2_score",  32'(a_s2),    32'(m_s2));
    chk("winner",    32'(a_win),   32'(m_win));
  endtask

  // Frame tick every third cycle on instance A.
  task automatic drive_a(input bit st, c1, c2);
    last_tk = (a_cyc % 3 == 2);
    a_cyc++;
    step_a(0, st, last_tk, c1, c2);
  endtask

  int  ticks, mvc, cnt;
  bit  seen, st_r, r, c1, c2;
  logic [2:0] pre;

  initial begin
    a_rst = 1; a_st = 0; a_tk = 0; a_c1 = 0; a_c2 = 0;
    b_rst = 1; b_st = 0; b_tk = 0; b_c1 = 0; b_c2 = 0;

    //    rst st tk c1 c2  state      rd mv cd s1 s2 win
    add(1, 0, 0, 0, 0,  IDLE,      1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  IDLE,      1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  CLEAR,     1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,  PLAY,      0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,  PLAY,      0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  PLAY,      0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1,  CRASH,     0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  CRASH,     0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0,  CRASH,     0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0,  GAMEOVER,  0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0,  CLEAR,     1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,  PLAY,      0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  PLAY,      0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1,  CRASH,     0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  CRASH,     0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  CLEAR,     1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  COUNTDOWN, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  PLAY,      0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  PLAY,      0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  PLAY,      0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  CRASH,     0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0,  IDLE,      1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  IDLE,      1, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      b_rst = tbl[i].rst; b_st = tbl[i].st; b_tk = tbl[i].tk; b_c1 = tbl[i].c1; b_c2 = tbl[i].c2;
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_state", i),   32'(b_state), 32'(tbl[i].state));
      chk($sformatf("tbl%0d_restore", i), 32'(b_rd),    32'(tbl[i].rd));
      chk($sformatf("tbl%0d_move", i),    32'(b_mv),    32'(tbl[i].mv));
      chk($sformatf("tbl%0d_cd", i),      32'(b_cd),    32'(tbl[i].cd));
      chk($sformatf("tbl%0d_p1", i),      32'(b_s1),    32'(tbl[i].s1));
      chk($sformatf("tbl%0d_p2", i),      32'(b_s2),    32'(tbl[i].s2));
      chk($sformatf("tbl%0d_win", i),     32'(b_win),   32'(tbl[i].win));
    end
    b_rst = 1;

    // Reset, then start edge to first move_en, with a start re-pulse mid-countdown.
    for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, 0);
    drive_a(1, 0, 0);
    ticks = 0; seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      drive_a(!(i >= 200 && i < 203), 0, 0);
      if (last_tk) ticks++;
      if (a_mv) seen = 1;
    end
    chk("first_move_seen", 32'(seen), 32'd1);
    chk("first_move_ticks", 32'(ticks), 32'(1 + SECS * FPS + SDIV));

    // Crash mid-frame by P1: P2 scores, then a full crash hold without move_en.
    while (a_cyc % 3 == 2) drive_a(1, 0, 0);
    drive_a(1, 1, 0);
    for (int i = 0; i < 10 && a_state != CRASH; i++) drive_a(1, 0, 0);
    chk("crash_state", 32'(a_state), 32'(CRASH));
    chk("crash_p2", 32'(a_s2), 32'd1);
    mvc = 0; cnt = 0;
    for (int i = 0; i < 1000 && a_state != CLEAR; i++) begin
      pre = a_state;
      drive_a(1, 0, 0);
      if (pre == CRASH && last_tk) cnt++;
      if (a_mv) mvc++;
    end
    chk("crash_to_clear", 32'(a_state), 32'(CLEAR));
    chk("crash_moves", 32'(mvc), 32'd0);
    chk("crash_ticks", 32'(cnt), 32'(CRASHF));

    // Same-cycle crash by P2 on a tick, then reset while in CRASH.
    for (int i = 0; i < 3000 && a_state != PLAY; i++) drive_a(1, 0, 0);
    chk("to_play2", 32'(a_state), 32'(PLAY));
    while (a_cyc % 3 != 2) drive_a(1, 0, 0);
    drive_a(1, 0, 1);
    chk("same_cycle_state", 32'(a_state), 32'(CRASH));
    chk("same_cycle_p1", 32'(a_s1), 32'd1);
    chk("same_cycle_move", 32'(a_mv), 32'd0);
    for (int i = 0; i < 5; i++) drive_a(1, 0, 0);
    step_a(1, 1, 0, 0, 0);
    chk("rst_state", 32'(a_state), 32'(IDLE));
    chk("rst_restore", 32'(a_rd), 32'd1);
    chk("rst_scores", 32'({a_s1, a_s2}), 32'd0);

    // Randomized run against the model; start begins high so release is not an edge.
    st_r = 1;
    for (int i = 0; i < 40000 && n_err < 40; i++) begin
      r = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 59) == 0) st_r = ~st_r;
      if (m_phase == PLAY) begin
        c1 = ($urandom_range(0, 79) == 0);
        c2 = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 399) == 0) begin c1 = 1; c2 = 1; end
      end else begin
        c1 = ($urandom_range(0, 19) == 0);
        c2 = ($urandom_range(0, 19) == 0);
      end
      if (r) step_a(1, st_r, 0, c1, c2);
      else drive_a(st_r, c1, c2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
